// File: rtl/axi_lite_if.sv
// axi_lite_if: 32-bit AXI4-Lite link (AW/W/B/AR/R channels) with master and slave modports
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_addr_decoder.sv
// axi_lite_addr_decoder: 1-to-2 AXI4-Lite router; ports aclk, areset_n (sync, low), s_axi_lite upstream, m0/m1_axi_lite downstream, decerr_count when AXI_DEC_ERRCNT_EN
module axi_lite_addr_decoder #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_SIZE = 32'h0000_1000,
  parameter logic [31:0] S1_BASE = 32'h0000_1000,
  parameter logic [31:0] S1_SIZE = 32'h0000_1000
) (
  input  logic        aclk,
  input  logic        areset_n,
  axi_lite_if.slave   s_axi_lite,
  axi_lite_if.master  m0_axi_lite,
  axi_lite_if.master  m1_axi_lite
`ifdef AXI_DEC_ERRCNT_EN
  ,
  output logic [15:0] decerr_count
`endif
);
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BRESP} w_st_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP, R_RDATA} r_st_t;
  function automatic logic [1:0] decode(input logic [31:0] a);
    logic h0, h1;
    h0 = ({1'b0, a} >= {1'b0, S0_BASE}) && ({1'b0, a} < {1'b0, S0_BASE} + {1'b0, S0_SIZE});
    h1 = ({1'b0, a} >= {1'b0, S1_BASE}) && ({1'b0, a} < {1'b0, S1_BASE} + {1'b0, S1_SIZE});
    return h0 ? 2'b01 : (h1 ? 2'b10 : 2'b00);
  endfunction
  w_st_t       w_st, w_nxt;
  logic        aw_held, w_held, aw_done, w_done;
  logic [31:0] awaddr_r, wdata_r;
  logic [3:0]  wstrb_r;
  logic [1:0]  wsel_r, bresp_r, wsel_nxt, m_bresp;
  logic        aw_hs, w_hs, pair, fwd0, fwd1, m_awready, m_wready, m_bvalid, m_aw_hs, m_w_hs;
  r_st_t       r_st, r_nxt;
  logic [31:0] araddr_r, rdata_r, m_rdata;
  logic [1:0]  rsel_r, rresp_r, rsel_in, m_rresp;
  logic        ar_hs, m_arready, m_rvalid;
  always_comb begin
    aw_hs     = s_axi_lite.awvalid && s_axi_lite.awready;
    w_hs      = s_axi_lite.wvalid && s_axi_lite.wready;
    wsel_nxt  = aw_hs ? decode(s_axi_lite.awaddr) : wsel_r;
    pair      = (aw_held || aw_hs) && (w_held || w_hs);
    fwd0      = (w_st == W_FWD) && wsel_r[0];
    fwd1      = (w_st == W_FWD) && wsel_r[1];
    m_awready = wsel_r[1] ? m1_axi_lite.awready : m0_axi_lite.awready;
    m_wready  = wsel_r[1] ? m1_axi_lite.wready : m0_axi_lite.wready;
    m_bvalid  = wsel_r[1] ? m1_axi_lite.bvalid : m0_axi_lite.bvalid;
    m_bresp   = wsel_r[1] ? m1_axi_lite.bresp : m0_axi_lite.bresp;
    m_aw_hs   = (w_st == W_FWD) && !aw_done && m_awready;
    m_w_hs    = (w_st == W_FWD) && !w_done && m_wready;
  end
  always_ff @(posedge aclk)
    if (!areset_n) w_st <= W_IDLE;
    else w_st <= w_nxt;
  always_comb begin
    w_nxt = (w_st == W_IDLE) ? (pair ? ((|wsel_nxt) ? W_FWD : W_BRESP) : W_IDLE) :
            (w_st == W_FWD)  ? (((aw_done || m_aw_hs) && (w_done || m_w_hs)) ? W_RESP : W_FWD) :
            (w_st == W_RESP) ? (m_bvalid ? W_BRESP : W_RESP) :
                               (s_axi_lite.bready ? W_IDLE : W_BRESP);
  end
  always_comb begin
    s_axi_lite.awready  = (w_st == W_IDLE) && !aw_held;
    s_axi_lite.wready   = (w_st == W_IDLE) && !w_held;
    s_axi_lite.bvalid   = (w_st == W_BRESP);
    s_axi_lite.bresp    = bresp_r;
    m0_axi_lite.awvalid = fwd0 && !aw_done;
    m0_axi_lite.awaddr  = fwd0 ? awaddr_r : '0;
    m0_axi_lite.wvalid  = fwd0 && !w_done;
    m0_axi_lite.wdata   = fwd0 ? wdata_r : '0;
    m0_axi_lite.wstrb   = fwd0 ? wstrb_r : '0;
    m0_axi_lite.bready  = (w_st == W_RESP) && wsel_r[0];
    m1_axi_lite.awvalid = fwd1 && !aw_done;
    m1_axi_lite.awaddr  = fwd1 ? awaddr_r : '0;
    m1_axi_lite.wvalid  = fwd1 && !w_done;
    m1_axi_lite.wdata   = fwd1 ? wdata_r : '0;
    m1_axi_lite.wstrb   = fwd1 ? wstrb_r : '0;
    m1_axi_lite.bready  = (w_st == W_RESP) && wsel_r[1];
  end
  always_ff @(posedge aclk)
    if (!areset_n) begin
      {aw_held, w_held, aw_done, w_done} <= '0;
      awaddr_r <= '0;
      wdata_r  <= '0;
      wstrb_r  <= '0;
      wsel_r   <= '0;
      bresp_r  <= '0;
    end else begin
      if (aw_hs) begin
        awaddr_r <= s_axi_lite.awaddr;
        wsel_r   <= wsel_nxt;
        aw_held  <= 1'b1;
      end
      if (w_hs) begin
        wdata_r <= s_axi_lite.wdata;
        wstrb_r <= s_axi_lite.wstrb;
        w_held  <= 1'b1;
      end
      if (m_aw_hs) aw_done <= 1'b1;
      if (m_w_hs) w_done <= 1'b1;
      if ((w_st == W_IDLE) && pair && !(|wsel_nxt)) bresp_r <= 2'b11;
      if ((w_st == W_RESP) && m_bvalid) bresp_r <= m_bresp;
      if (s_axi_lite.bvalid && s_axi_lite.bready) {aw_held, w_held, aw_done, w_done} <= '0;
    end
  always_comb begin
    ar_hs     = s_axi_lite.arvalid && s_axi_lite.arready;
    rsel_in   = decode(s_axi_lite.araddr);
    m_arready = rsel_r[1] ? m1_axi_lite.arready : m0_axi_lite.arready;
    m_rvalid  = rsel_r[1] ? m1_axi_lite.rvalid : m0_axi_lite.rvalid;
    m_rdata   = rsel_r[1] ? m1_axi_lite.rdata : m0_axi_lite.rdata;
    m_rresp   = rsel_r[1] ? m1_axi_lite.rresp : m0_axi_lite.rresp;
  end
  always_ff @(posedge aclk)
    if (!areset_n) r_st <= R_IDLE;
    else r_st <= r_nxt;
  always_comb begin
    r_nxt = (r_st == R_IDLE) ? (ar_hs ? ((|rsel_in) ? R_FWD : R_RDATA) : R_IDLE) :
            (r_st == R_FWD)  ? (m_arready ? R_RESP : R_FWD) :
            (r_st == R_RESP) ? (m_rvalid ? R_RDATA : R_RESP) :
                               (s_axi_lite.rready ? R_IDLE : R_RDATA);
  end
  always_comb begin
    s_axi_lite.arready  = (r_st == R_IDLE);
    s_axi_lite.rvalid   = (r_st == R_RDATA);
    s_axi_lite.rdata    = rdata_r;
    s_axi_lite.rresp    = rresp_r;
    m0_axi_lite.arvalid = (r_st == R_FWD) && rsel_r[0];
    m0_axi_lite.araddr  = ((r_st == R_FWD) && rsel_r[0]) ? araddr_r : '0;
    m0_axi_lite.rready  = (r_st == R_RESP) && rsel_r[0];
    m1_axi_lite.arvalid = (r_st == R_FWD) && rsel_r[1];
    m1_axi_lite.araddr  = ((r_st == R_FWD) && rsel_r[1]) ? araddr_r : '0;
    m1_axi_lite.rready  = (r_st == R_RESP) && rsel_r[1];
  end
  always_ff @(posedge aclk)
    if (!areset_n) begin
      araddr_r <= '0;
      rsel_r   <= '0;
      rdata_r  <= '0;
      rresp_r  <= '0;
    end else begin
      if (ar_hs) begin
        araddr_r <= s_axi_lite.araddr;
        rsel_r   <= rsel_in;
        if (!(|rsel_in)) begin
          rdata_r <= '0;
          rresp_r <= 2'b11;
        end
      end
      if ((r_st == R_RESP) && m_rvalid) begin
        rdata_r <= m_rdata;
        rresp_r <= m_rresp;
      end
    end
`ifdef AXI_DEC_ERRCNT_EN
  logic [16:0] cnt_sum;
  always_comb
    cnt_sum = {1'b0, decerr_count}
            + 17'(s_axi_lite.bvalid && s_axi_lite.bready && !(|wsel_r))
            + 17'(s_axi_lite.rvalid && s_axi_lite.rready && !(|rsel_r));
  always_ff @(posedge aclk)
    if (!areset_n) decerr_count <= '0;
    else decerr_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
`endif
endmodule

// File: tb/tb_axi_lite_addr_decoder.sv
// tb_axi_lite_addr_decoder: scoreboard bench for the AXI4-Lite 1-to-2 address decoder
module tb_axi_lite_addr_decoder;
  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;
  axi_lite_if s_if();
  axi_lite_if m0_if();
  axi_lite_if m1_if();
  axi_lite_if ov_s();
  axi_lite_if ov_m0();
  axi_lite_if ov_m1();
`ifdef AXI_DEC_ERRCNT_EN
  logic [15:0] decerr_count, ov_cnt;
`endif
  axi_lite_addr_decoder u_dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_axi_lite(s_if), .m0_axi_lite(m0_if), .m1_axi_lite(m1_if)
`ifdef AXI_DEC_ERRCNT_EN
    , .decerr_count(decerr_count)
`endif
  );
  axi_lite_addr_decoder #(.S1_BASE(32'h0000_0800), .S1_SIZE(32'h0000_1000)) u_ovl (
    .aclk(aclk), .areset_n(areset_n),
    .s_axi_lite(ov_s), .m0_axi_lite(ov_m0), .m1_axi_lite(ov_m1)
`ifdef AXI_DEC_ERRCNT_EN
    , .decerr_count(ov_cnt)
`endif
  );
  int passed = 0;
  int total = 0;
  int bdel0 = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [32:0] exp_m0[$];
  logic [32:0] exp_m1[$];
  logic [31:0] exp_ov[$];
  logic [31:0] mem0 [0:1023];
  logic [31:0] mem1 [0:1023];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic unexp(input string nm);
    total++;
    $display("FAIL %s: unexpected transfer with nothing expected", nm);
  endtask
  initial forever begin
    @(negedge aclk);
    #1;
    if (areset_n) begin
      if (s_if.bvalid && s_if.bready) begin
        if (exp_b.size() == 0) unexp("s_b");
        else chk("s_bresp", s_if.bresp, exp_b.pop_front());
      end
      if (s_if.rvalid && s_if.rready) begin
        if (exp_r.size() == 0) unexp("s_r");
        else chk("s_rresp_rdata", {s_if.rresp, s_if.rdata}, exp_r.pop_front());
      end
      if (m0_if.awvalid) begin
        if (exp_m0.size() == 0) unexp("m0_aw");
        else chk("m0_aw", {1'b0, m0_if.awaddr}, exp_m0.pop_front());
      end
      if (m0_if.arvalid) begin
        if (exp_m0.size() == 0) unexp("m0_ar");
        else chk("m0_ar", {1'b1, m0_if.araddr}, exp_m0.pop_front());
      end
      if (m1_if.awvalid) begin
        if (exp_m1.size() == 0) unexp("m1_aw");
        else chk("m1_aw", {1'b0, m1_if.awaddr}, exp_m1.pop_front());
      end
      if (m1_if.arvalid) begin
        if (exp_m1.size() == 0) unexp("m1_ar");
        else chk("m1_ar", {1'b1, m1_if.araddr}, exp_m1.pop_front());
      end
      if (ov_s.rvalid && ov_s.rready) begin
        if (exp_ov.size() == 0) unexp("ov_r");
        else chk("ov_rdata", {ov_s.rresp, ov_s.rdata}, {2'b00, exp_ov.pop_front()});
      end
      if (ov_m1.arvalid) unexp("ov_m1_ar");
    end
  end
  initial begin
    logic ga, gw;
    logic [31:0] a, d;
    int i;
    m0_if.awready = 1'b1; m0_if.wready = 1'b1; m0_if.bvalid = 1'b0; m0_if.bresp = 2'b00;
    ga = 1'b0; gw = 1'b0; a = '0; d = '0;
    for (int j = 0; j < 1024; j++) mem0[j] = '0;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        ga = 1'b0; gw = 1'b0;
      end else begin
        if (m0_if.awvalid) begin ga = 1'b1; a = m0_if.awaddr; end
        if (m0_if.wvalid) begin gw = 1'b1; d = m0_if.wdata; end
        if (ga && gw) begin
          ga = 1'b0; gw = 1'b0; mem0[a[11:2]] = d; i = 0;
          while (i <= bdel0 && areset_n) begin @(negedge aclk); i++; end
          if (areset_n) begin
            m0_if.bvalid = 1'b1; i = 0;
            while (!m0_if.bready && areset_n && i < 100) begin @(negedge aclk); i++; end
            if (areset_n && m0_if.bready) begin @(posedge aclk); #1; end
            m0_if.bvalid = 1'b0;
          end
        end
      end
    end
  end
  initial begin
    logic ga, gw;
    logic [31:0] a, d;
    int i;
    m1_if.awready = 1'b1; m1_if.wready = 1'b1; m1_if.bvalid = 1'b0; m1_if.bresp = 2'b00;
    ga = 1'b0; gw = 1'b0; a = '0; d = '0;
    for (int j = 0; j < 1024; j++) mem1[j] = '0;
    mem1[8] = 32'h5555_1020;
    forever begin
      @(negedge aclk);
      if (!areset_n) begin
        ga = 1'b0; gw = 1'b0;
      end else begin
        if (m1_if.awvalid) begin ga = 1'b1; a = m1_if.awaddr; end
        if (m1_if.wvalid) begin gw = 1'b1; d = m1_if.wdata; end
        if (ga && gw) begin
          ga = 1'b0; gw = 1'b0; mem1[a[11:2]] = d;
          @(negedge aclk);
          if (areset_n) begin
            m1_if.bvalid = 1'b1; i = 0;
            while (!m1_if.bready && areset_n && i < 100) begin @(negedge aclk); i++; end
            if (areset_n && m1_if.bready) begin @(posedge aclk); #1; end
            m1_if.bvalid = 1'b0;
          end
        end
      end
    end
  end
  initial begin
    logic [31:0] a;
    int i;
    m0_if.arready = 1'b1; m0_if.rvalid = 1'b0; m0_if.rdata = '0; m0_if.rresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (areset_n && m0_if.arvalid) begin
        a = m0_if.araddr;
        @(negedge aclk);
        m0_if.rdata = mem0[a[11:2]]; m0_if.rvalid = 1'b1; i = 0;
        while (!m0_if.rready && areset_n && i < 100) begin @(negedge aclk); i++; end
        if (areset_n && m0_if.rready) begin @(posedge aclk); #1; end
        m0_if.rvalid = 1'b0;
      end
    end
  end
  initial begin
    logic [31:0] a;
    int i;
    m1_if.arready = 1'b1; m1_if.rvalid = 1'b0; m1_if.rdata = '0; m1_if.rresp = 2'b00;
    forever begin
      @(negedge aclk);
      if (areset_n && m1_if.arvalid) begin
        a = m1_if.araddr;
        @(negedge aclk);
        m1_if.rdata = mem1[a[11:2]]; m1_if.rvalid = 1'b1; i = 0;
        while (!m1_if.rready && areset_n && i < 100) begin @(negedge aclk); i++; end
        if (areset_n && m1_if.rready) begin @(posedge aclk); #1; end
        m1_if.rvalid = 1'b0;
      end
    end
  end
  initial begin
    ov_m0.awready = 1'b0; ov_m0.wready = 1'b0; ov_m0.bvalid = 1'b0; ov_m0.bresp = 2'b00;
    ov_m0.arready = 1'b1; ov_m0.rvalid = 1'b1; ov_m0.rdata = 32'h0000_AAAA; ov_m0.rresp = 2'b00;
    ov_m1.awready = 1'b0; ov_m1.wready = 1'b0; ov_m1.bvalid = 1'b0; ov_m1.bresp = 2'b00;
    ov_m1.arready = 1'b1; ov_m1.rvalid = 1'b1; ov_m1.rdata = 32'h0000_BBBB; ov_m1.rresp = 2'b00;
  end
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int lead);
    int k;
    logic ad, wd, ag, wg;
    s_if.awaddr = a; s_if.wdata = d; s_if.wstrb = 4'hF;
    s_if.wvalid = 1'b1; s_if.awvalid = (lead == 0);
    ad = 1'b0; wd = 1'b0; k = 0;
    while (!(ad && wd) && k < 50) begin
      ag = s_if.awvalid && s_if.awready;
      wg = s_if.wvalid && s_if.wready;
      @(negedge aclk);
      k++;
      if (ag) begin s_if.awvalid = 1'b0; ad = 1'b1; end
      if (wg) begin s_if.wvalid = 1'b0; wd = 1'b1; end
      if (k == lead) s_if.awvalid = 1'b1;
    end
    if (!(ad && wd)) begin
      total++;
      $display("FAIL wr_accept: addr %0h not accepted, got aw=%0d w=%0d required 1 1", a, ad, wd);
      s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    end
  endtask
  task automatic rd(input logic [31:0] a);
    int k;
    s_if.araddr = a; s_if.arvalid = 1'b1; k = 0;
    while (!s_if.arready && k < 50) begin @(negedge aclk); k++; end
    if (k == 50) begin
      total++;
      $display("FAIL rd_accept: addr %0h got arready 0 required 1", a);
    end
    @(negedge aclk);
    s_if.arvalid = 1'b0;
  endtask
  task automatic drain();
    int k;
    k = 0;
    while ((exp_b.size() + exp_r.size() + exp_m0.size() + exp_m1.size() + exp_ov.size()) != 0 && k < 200) begin
      @(negedge aclk);
      k++;
    end
    if (k == 200) begin
      total++;
      $display("FAIL drain: got %0d outstanding responses required 0",
               exp_b.size() + exp_r.size() + exp_m0.size() + exp_m1.size() + exp_ov.size());
    end
    @(negedge aclk);
  endtask
  initial begin
    int k;
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0; s_if.arvalid = 1'b0;
    s_if.awaddr = '0; s_if.wdata = '0; s_if.wstrb = '0; s_if.araddr = '0;
    s_if.bready = 1'b1; s_if.rready = 1'b1;
    ov_s.awvalid = 1'b0; ov_s.wvalid = 1'b0; ov_s.arvalid = 1'b0;
    ov_s.awaddr = '0; ov_s.wdata = '0; ov_s.wstrb = '0; ov_s.araddr = '0;
    ov_s.bready = 1'b1; ov_s.rready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_readies", {s_if.awready, s_if.wready, s_if.arready}, 3'b111);
    chk("rst_s_valids", {s_if.bvalid, s_if.rvalid}, 2'b00);
    chk("rst_m0_out", {m0_if.awvalid, m0_if.wvalid, m0_if.arvalid, m0_if.bready, m0_if.rready}, 5'b0);
    chk("rst_m1_out", {m1_if.awvalid, m1_if.wvalid, m1_if.arvalid, m1_if.bready, m1_if.rready}, 5'b0);
    areset_n = 1'b1;
    @(negedge aclk);
    exp_m0.push_back({1'b0, 32'h0000_0010}); exp_b.push_back(2'b00);
    wr(32'h0000_0010, 32'hDEAD_BEEF, 0);
    chk("t1_m0_valids", {m0_if.awvalid, m0_if.wvalid}, 2'b11);
    chk("t1_m0_wdata_strb", {m0_if.wstrb, m0_if.wdata}, {4'hF, 32'hDEAD_BEEF});
    chk("t1_m1_idle", {m1_if.awvalid, m1_if.wvalid, m1_if.awaddr}, '0);
    drain();
    exp_m0.push_back({1'b1, 32'h0000_0010}); exp_r.push_back({2'b00, 32'hDEAD_BEEF});
    rd(32'h0000_0010);
    drain();
    exp_m1.push_back({1'b0, 32'h0000_1004}); exp_b.push_back(2'b00);
    wr(32'h0000_1004, 32'h1234_5678, 3);
    drain();
    exp_m1.push_back({1'b1, 32'h0000_1004}); exp_r.push_back({2'b00, 32'h1234_5678});
    rd(32'h0000_1004);
    drain();
    exp_r.push_back({2'b11, 32'h0});
    rd(32'h0000_2000);
    drain();
    exp_b.push_back(2'b11);
    wr(32'h0000_2000, 32'h5A5A_5A5A, 0);
    drain();
`ifdef AXI_DEC_ERRCNT_EN
    chk("decerr_count", decerr_count, 16'd2);
`endif
    exp_m0.push_back({1'b0, 32'h0000_0020}); exp_b.push_back(2'b00);
    exp_m1.push_back({1'b1, 32'h0000_1020}); exp_r.push_back({2'b00, 32'h5555_1020});
    fork
      wr(32'h0000_0020, 32'hCAFE_0020, 0);
      rd(32'h0000_1020);
    join
    drain();
    s_if.bready = 1'b0;
    exp_m0.push_back({1'b0, 32'h0000_0030}); exp_b.push_back(2'b00);
    wr(32'h0000_0030, 32'h0000_3030, 0);
    k = 0;
    while (!s_if.bvalid && k < 20) begin @(negedge aclk); k++; end
    repeat (5) begin
      @(negedge aclk);
      chk("hold_b", {s_if.bvalid, s_if.bresp, s_if.awready, s_if.wready}, 5'b1_00_0_0);
    end
    s_if.bready = 1'b1;
    drain();
    exp_m0.push_back({1'b1, 32'h0000_0020}); exp_r.push_back({2'b00, 32'hCAFE_0020});
    rd(32'h0000_0020);
    drain();
    bdel0 = 20;
    exp_m0.push_back({1'b0, 32'h0000_0040});
    wr(32'h0000_0040, 32'h0000_4040, 0);
    @(negedge aclk);
    chk("wresp_m0_bready", m0_if.bready, 1'b1);
    areset_n = 1'b0;
    @(negedge aclk);
    chk("rst2_readies", {s_if.awready, s_if.wready, s_if.arready}, 3'b111);
    chk("rst2_valids", {s_if.bvalid, s_if.rvalid, m0_if.awvalid, m0_if.wvalid, m0_if.arvalid, m0_if.bready, m0_if.rready}, 7'b0);
    @(negedge aclk);
    areset_n = 1'b1;
    bdel0 = 0;
    @(negedge aclk);
    exp_m0.push_back({1'b0, 32'h0000_0000}); exp_b.push_back(2'b00);
    wr(32'h0000_0000, 32'h0BAD_F00D, 0);
    drain();
    exp_m0.push_back({1'b1, 32'h0000_0000}); exp_r.push_back({2'b00, 32'h0BAD_F00D});
    rd(32'h0000_0000);
    drain();
    exp_ov.push_back(32'h0000_AAAA);
    ov_s.araddr = 32'h0000_0900; ov_s.arvalid = 1'b1;
    @(negedge aclk);
    ov_s.arvalid = 1'b0;
    chk("ovl_route", {ov_m0.arvalid, ov_m1.arvalid, ov_m0.araddr}, {2'b10, 32'h0000_0900});
    drain();
    chk("queues_empty", exp_b.size() + exp_r.size() + exp_m0.size() + exp_m1.size() + exp_ov.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axi_lite_addr_decoder.md
Name: axi_lite_addr_decoder

Overview:
- 1-to-2 AXI4-Lite address decoder/router between the single axi_lite_master and up to two axi_lite_slave instances, on axi_lite_if links.
- Decodes each AW/AR address against two parameterised windows and forwards the transaction to the matching slave.
- Returns that slave's response upstream, or a locally generated DECERR for unmapped addresses.
- Independent write and read engines; one outstanding transaction per direction.

Parameters:
- S0_BASE, 32'h0000_0000, base address of slave 0 window
- S0_SIZE, 32'h0000_1000, byte size of slave 0 window
- S1_BASE, 32'h0000_1000, base address of slave 1 window
- S1_SIZE, 32'h0000_1000, byte size of slave 1 window

Ports:
- aclk  input  1  clock; all logic on its rising edge
- areset_n  input  1  synchronous active-low reset
- s_axi_lite  axi_lite_if.slave  32b addr / 32b data / 4b strb / 2b resp  upstream link from master
- m0_axi_lite  axi_lite_if.master  same  downstream link to slave 0
- m1_axi_lite  axi_lite_if.master  same  downstream link to slave 1
- decerr_count  output  16  DECERR counter; present only with AXI_DEC_ERRCNT_EN

Behaviour:
- Decode: hit_n = (addr >= Sn_BASE) && (addr < Sn_BASE + Sn_SIZE), compared in 33-bit arithmetic so no wrap at 2^32. Both hit: slave 0 wins. Neither hit: DECERR.
- Addresses and write strobes are forwarded unmodified (full address, no offset subtraction).
- Reset (areset_n low at a clock edge) returns both FSMs to IDLE and clears all captured registers. Every valid and ready output is 0 at reset, except s.awready, s.wready and s.arready, which are 1 (IDLE). Reset mid-transaction abandons the transaction with no response.
- Write FSM states: W_IDLE, W_FWD, W_RESP, W_BRESP.
  - W_IDLE: s.awready=1 until AW is captured and s.wready=1 until W is captured. AW and W are accepted in either order or in the same cycle. Address, data, strobe and decoded select are captured into registers.
  - When both AW and W are held: if mapped, go to W_FWD; if unmapped, go to W_BRESP with resp=2'b11.
  - W_FWD: drive m_sel.awvalid and m_sel.wvalid from the cycle after the capture that completes the pair. Each valid stays high until its own handshake. AW and W handshakes may complete in different cycles. When both are done, go to W_RESP.
  - W_RESP: m_sel.bready=1. On bvalid&&bready, capture bresp and go to W_BRESP.
  - W_BRESP: s.bvalid=1 with the captured resp until s.bready. Then return to W_IDLE, where awready and wready reassert in the next cycle.
  - Minimum latency: upstream handshake at cycle N → downstream valids at N+1. Downstream B at cycle M → upstream bvalid at M+1.
- Read FSM states: R_IDLE, R_FWD, R_RESP, R_RDATA.
  - R_IDLE: s.arready=1. Capture address and select.
  - Mapped address: go to R_FWD, drive m_sel.arvalid until handshake, then go to R_RESP.
  - R_RESP: m_sel.rready=1. Capture rdata and rresp, then go to R_RDATA.
  - Unmapped address: go directly to R_RDATA with rdata=32'h0 and rresp=2'b11.
  - R_RDATA: s.rvalid held until s.rready, then return to R_IDLE.
- Non-selected downstream port: all valids and readies 0, address/data outputs held at 0.
- Concurrent read and write are allowed, including to the same slave. The two FSMs share no state.
- Upstream valid/data stability is assumed from the master per AXI; the decoder never deasserts an output valid before its handshake.

Optional Feature:
- Macro: AXI_DEC_ERRCNT_EN.
- When defined: the decerr_count port exists. It is a 16-bit saturating counter, cleared by reset. It increments by 1 on each write DECERR completion (s.bvalid&&s.bready with resp 2'b11 generated locally) and on each read DECERR completion. A simultaneous write and read DECERR adds 2. It saturates at 16'hFFFF.
- When not defined: no port and no counter logic.

Test Plan:
- Write addr 32'h0000_0010, data 32'hDEAD_BEEF, strb 4'hF → m0 receives AW/W one cycle after capture; m1 stays idle. Slave 0 OKAY → s.bresp=2'b00. Readback of 32'h10 returns 32'hDEAD_BEEF with rresp 2'b00.
- Write 32'h0000_1004 with W presented 3 cycles before AW → routed to m1 once AW arrives. Readback via m1 matches; m0 stays untouched.
- Read 32'h0000_2000 (unmapped) → s.rdata=32'h0 and s.rresp=2'b11 with no downstream activity. Write to the same address → s.bresp=2'b11; decerr_count=2 when AXI_DEC_ERRCNT_EN is defined.
- Write to 32'h0000_0020 concurrent with read of 32'h0000_1020 → both complete correctly. Upstream bready held 0 for 5 cycles → bvalid stays high with stable resp, and no new AW is accepted until B completes.
- Assert areset_n=0 while in W_RESP → next cycle: all valids 0, awready/wready/arready=1. A fresh write to 32'h0000_0000 completes normally.
- Overlap config S1_BASE=32'h0000_0800, S1_SIZE=32'h1000; read 32'h0000_0900 → routed to m0 (slave 0 priority).
